// File: rtl/ising_ctrl_pkg.sv
// Shared definitions for the Ising run sequencer: FSM states,
// host register offsets and CTRL bit positions.
package ising_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  localparam logic [7:0] ADDR_CTRL          = 8'h00;
  localparam logic [7:0] ADDR_RUN_CYCLES    = 8'h04;
  localparam logic [7:0] ADDR_NUM_RUNS      = 8'h08;
  localparam logic [7:0] ADDR_SETTLE_CYCLES = 8'h0C;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

endpackage

// File: rtl/ising_spin_sync.sv
// Two-flop synchronizer bringing the free-running oscillator spin
// states into the clk domain. Runs continuously.
module ising_spin_sync #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         axi_rstn,
  input  logic [N-1:0] i_spins,
  output logic [N-1:0] o_spins
);

  logic [N-1:0] r_meta;
  logic [N-1:0] r_sync;

  // Capture the asynchronous spins, then resample to settle metastability
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_spins;
      r_sync <= r_meta;
    end
  end

  assign o_spins = r_sync;

endmodule

// File: rtl/ising_run_ctrl.sv
// Run sequencer for the ising_axi spin array: host register decode,
// clear/anneal/freeze/snapshot sequencing and snapshot handshake.
module ising_run_ctrl
  import ising_ctrl_pkg::*;
#(
  parameter int N          = 64,
  parameter int CNT_W      = 32,
  parameter int CLR_CYCLES = 4,
  parameter int RUN_RST    = 1000,
  parameter int SETTLE_RST = 8
) (
  input  logic             clk,
  input  logic             axi_rstn,
  input  logic             cfg_wr_en,
  input  logic [7:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic [N-1:0]     spins_in,
  output logic             ising_clr,
  output logic             ising_en,
  output logic [N-1:0]     snap,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] run_cnt
);

  function automatic logic [CNT_W-1:0] f_min1(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // Settle must outlast the two synchronizer flops.
  function automatic logic [CNT_W-1:0] f_min2(input logic [CNT_W-1:0] v);
    return (v < CNT_W'(2)) ? CNT_W'(2) : v;
  endfunction

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] r_run_cycles, r_settle_cycles, r_num_runs;
  logic [CNT_W-1:0] r_sh_run, r_sh_settle, r_sh_num;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  state_t           r_state, w_next;
  logic [N-1:0]     w_spins_sync;
  logic             r_clr, r_en, r_snap_valid, r_done, r_aborted;
  logic [N-1:0]     r_snap;
  logic [CNT_W-1:0] r_run_cnt;
  logic             w_ctrl_wr, w_abort, w_start, w_timer_done, w_hs, w_last;

  ising_spin_sync #(.N(N)) u_sync (
    .clk      (clk),
    .axi_rstn (axi_rstn),
    .i_spins  (spins_in),
    .o_spins  (w_spins_sync)
  );

  assign w_ctrl_wr    = cfg_wr_en && (cfg_addr == ADDR_CTRL);
  assign w_abort      = w_ctrl_wr && cfg_wdata[CTRL_ABORT_BIT];
  // ABORT in the same beat drops START; START while busy is ignored.
  assign w_start      = w_ctrl_wr && cfg_wdata[CTRL_START_BIT] && !w_abort &&
                        (r_state == ST_IDLE);
  assign w_timer_done = (r_cnt == CNT_W'(1));
  assign w_hs         = (r_state == ST_CAPTURE) && snap_ready && !w_abort;
  // Compared one bit wider so a saturated count never wraps onto NUM_RUNS=0.
  assign w_last       = ({1'b0, r_run_cnt} + (CNT_W+1)'(1)) == {1'b0, r_sh_num};

  // Next-state and shared down-counter reload on each timed-state entry
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next     = ST_CLEAR;
          w_cnt_next = CNT_W'(CLR_CYCLES);
        end
      end
      ST_CLEAR: begin
        if (w_timer_done) begin
          w_next     = ST_RUN;
          w_cnt_next = f_min1(r_sh_run);
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (w_timer_done) begin
          w_next     = ST_SETTLE;
          w_cnt_next = f_min2(r_sh_settle);
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (w_timer_done) begin
          w_next = ST_CAPTURE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        if (w_hs) begin
          if (w_last) begin
            w_next = ST_IDLE;
          end else begin
            w_next     = ST_CLEAR;
            w_cnt_next = CNT_W'(CLR_CYCLES);
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  // Host-visible configuration registers; writable at any time
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_run_cycles    <= CNT_W'(RUN_RST);
      r_settle_cycles <= CNT_W'(SETTLE_RST);
      r_num_runs      <= CNT_W'(1);
    end else if (cfg_wr_en) begin
      if (cfg_addr == ADDR_RUN_CYCLES)    r_run_cycles    <= CNT_W'(cfg_wdata);
      if (cfg_addr == ADDR_SETTLE_CYCLES) r_settle_cycles <= CNT_W'(cfg_wdata);
      if (cfg_addr == ADDR_NUM_RUNS)      r_num_runs      <= CNT_W'(cfg_wdata);
    end
  end

  // Shadow copies frozen at START so mid-sequence writes wait for the next run
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_sh_run    <= CNT_W'(RUN_RST);
      r_sh_settle <= CNT_W'(SETTLE_RST);
      r_sh_num    <= CNT_W'(1);
    end else if (w_start) begin
      r_sh_run    <= r_run_cycles;
      r_sh_settle <= r_settle_cycles;
      r_sh_num    <= r_num_runs;
    end
  end

  // State, counter and outputs registered from the next-state decode
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_clr        <= 1'b0;
      r_en         <= 1'b0;
      r_snap_valid <= 1'b0;
      r_snap       <= '0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_run_cnt    <= '0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_next;
      r_clr        <= (w_next == ST_CLEAR);
      r_en         <= (w_next == ST_RUN);
      r_snap_valid <= (w_next == ST_CAPTURE);
      if ((w_next == ST_CAPTURE) && (r_state != ST_CAPTURE)) r_snap <= w_spins_sync;
      if (w_abort)                r_aborted <= 1'b1;
      else if (w_start)           r_aborted <= 1'b0;
      if (w_start)                r_done    <= 1'b0;
      else if (w_hs && w_last)    r_done    <= 1'b1;
      if (w_start)                r_run_cnt <= '0;
      else if (w_hs)              r_run_cnt <= f_sat_inc(r_run_cnt);
    end
  end

  assign ising_clr  = r_clr;
  assign ising_en   = r_en;
  assign snap       = r_snap;
  assign snap_valid = r_snap_valid;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;
  assign aborted    = r_aborted;
  assign run_cnt    = r_run_cnt;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed self-checking bench for ising_run_ctrl.
module tb_ising_run_ctrl;

  localparam int N     = 64;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             axi_rstn;
  logic             cfg_wr_en;
  logic [7:0]       cfg_addr;
  logic [31:0]      cfg_wdata;
  logic [N-1:0]     spins_in;
  logic             ising_clr, ising_en, snap_valid, snap_ready;
  logic [N-1:0]     snap;
  logic             busy, done, aborted;
  logic [CNT_W-1:0] run_cnt;

  int n_checks = 0;
  int n_errors = 0;

  int cyc, en_cnt, en_first, clr_cnt, clr_first, sv_cnt, sv_first, hs_cnt;
  logic [N-1:0] pat [4];

  ising_run_ctrl #(.N(N), .CNT_W(CNT_W), .CLR_CYCLES(4), .RUN_RST(1000), .SETTLE_RST(8)) dut (
    .clk        (clk),
    .axi_rstn   (axi_rstn),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .spins_in   (spins_in),
    .ising_clr  (ising_clr),
    .ising_en   (ising_en),
    .snap       (snap),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .run_cnt    (run_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] d);
    cfg_wr_en = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic clear_stats();
    cyc = 1; en_cnt = 0; en_first = -1; clr_cnt = 0; clr_first = -1;
    sv_cnt = 0; sv_first = -1; hs_cnt = 0;
  endtask

  task automatic sample_cycle();
    if (ising_en)  begin en_cnt++;  if (en_first  < 0) en_first  = cyc; end
    if (ising_clr) begin clr_cnt++; if (clr_first < 0) clr_first = cyc; end
    if (snap_valid) begin
      sv_cnt++;
      if (sv_first < 0) sv_first = cyc;
      if (snap_ready) hs_cnt++;
    end
    tick();
    cyc++;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (snap_valid) break;
      tick();
    end
    check(tag, 64'(snap_valid), 64'd1);
  endtask

  initial begin
    axi_rstn = 1'b0; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    spins_in = '0; snap_ready = 1'b0;
    pat[0] = 64'h0123_4567_89AB_CDEF;
    pat[1] = 64'hFEDC_BA98_7654_3210;
    pat[2] = 64'h0F0F_F0F0_3C3C_C3C3;
    pat[3] = 64'h1111_2222_4444_8888;
    tick(); tick();
    // reset state
    check("rst_busy", 64'(busy), 0);
    check("rst_outs", {58'd0, ising_clr, ising_en, snap_valid, done, aborted, 1'b0}, 0);
    check("rst_cnt",  64'(run_cnt), 0);
    check("rst_snap", snap, 0);
    axi_rstn = 1'b1;
    tick();

    // single run, no back-pressure
    write_reg(8'h04, 32'd10);
    write_reg(8'h0C, 32'd4);
    write_reg(8'h08, 32'd1);
    snap_ready = 1'b1;
    spins_in   = pat[3];
    write_reg(8'h00, 32'h1);
    check("t1_busy_t1", 64'(busy), 1);
    clear_stats();
    repeat (25) sample_cycle();
    check("t1_clr_first", 64'(clr_first), 1);
    check("t1_clr_cnt",   64'(clr_cnt), 4);
    check("t1_en_first",  64'(en_first), 5);
    check("t1_en_cnt",    64'(en_cnt), 10);
    check("t1_sv_first",  64'(sv_first), 19);
    check("t1_sv_cnt",    64'(sv_cnt), 1);
    check("t1_done",      64'(done), 1);
    check("t1_busy",      64'(busy), 0);
    check("t1_run_cnt",   64'(run_cnt), 1);
    check("t1_snap",      snap, pat[3]);

    // START|ABORT in IDLE: only aborted sets
    write_reg(8'h00, 32'h3);
    check("t4_aborted", 64'(aborted), 1);
    check("t4_busy",    64'(busy), 0);
    check("t4_done",    64'(done), 1);
    tick();
    check("t4_busy2",   64'(busy), 0);

    // three runs with 7-cycle stall per capture
    write_reg(8'h08, 32'd3);
    snap_ready = 1'b0;
    spins_in   = pat[0];
    write_reg(8'h00, 32'h1);
    check("t2_aborted_clr", 64'(aborted), 0);
    check("t2_busy",        64'(busy), 1);
    for (int r = 0; r < 3; r++) begin
      wait_valid("t2_wait_valid");
      check("t2_snap",     snap, pat[r]);
      check("t2_cnt_pre",  64'(run_cnt), 64'(r));
      check("t2_done_pre", 64'(done), 0);
      spins_in = pat[r+1];
      repeat (7) tick();
      check("t2_stall_snap",  snap, pat[r]);
      check("t2_stall_valid", 64'(snap_valid), 1);
      snap_ready = 1'b1;
      tick();
      snap_ready = 1'b0;
      check("t2_cnt_post", 64'(run_cnt), 64'(r + 1));
      check("t2_sv_fall",  64'(snap_valid), 0);
      if (r < 2) begin
        check("t2_clr_next", 64'(ising_clr), 1);
        check("t2_done_mid", 64'(done), 0);
      end else begin
        check("t2_done_end", 64'(done), 1);
        check("t2_busy_end", 64'(busy), 0);
      end
    end

    // abort during RUN of run 2; START while busy ignored
    snap_ready = 1'b1;
    spins_in   = pat[1];
    write_reg(8'h00, 32'h1);
    for (int i = 0; i < 100; i++) begin
      if (ising_en && run_cnt == 1) break;
      tick();
    end
    tick(); tick();
    check("t3_in_run2", {63'd0, ising_en}, 1);
    write_reg(8'h00, 32'h1);
    check("t3_restart_busy", 64'(busy), 1);
    check("t3_restart_en",   64'(ising_en), 1);
    check("t3_restart_cnt",  64'(run_cnt), 1);
    write_reg(8'h00, 32'h2);
    check("t3_en",      64'(ising_en), 0);
    check("t3_clr",     64'(ising_clr), 0);
    check("t3_sv",      64'(snap_valid), 0);
    check("t3_busy",    64'(busy), 0);
    check("t3_aborted", 64'(aborted), 1);
    check("t3_done",    64'(done), 0);
    check("t3_cnt",     64'(run_cnt), 1);
    check("t3_snap",    snap, pat[1]);

    // RUN=0 / SETTLE=0 minimums, RUN_CYCLES written mid-sequence
    write_reg(8'h04, 32'd0);
    write_reg(8'h0C, 32'd0);
    write_reg(8'h08, 32'd1);
    write_reg(8'h00, 32'h1);
    clear_stats();
    cfg_wr_en = 1'b1; cfg_addr = 8'h04; cfg_wdata = 32'd5;
    sample_cycle();
    cfg_wr_en = 1'b0;
    repeat (14) sample_cycle();
    check("t5_en_first", 64'(en_first), 5);
    check("t5_en_cnt",   64'(en_cnt), 1);
    check("t5_sv_first", 64'(sv_first), 8);
    check("t5_done",     64'(done), 1);

    // new RUN_CYCLES applied; spins pattern set mid-RUN reaches snap
    spins_in = '0;
    write_reg(8'h00, 32'h1);
    clear_stats();
    repeat (6) sample_cycle();
    spins_in = 64'hA5A5_A5A5_A5A5_A5A5;
    repeat (10) sample_cycle();
    check("t6_en_first", 64'(en_first), 5);
    check("t6_en_cnt",   64'(en_cnt), 5);
    check("t6_sv_first", 64'(sv_first), 12);
    check("t6_snap",     snap, 64'hA5A5_A5A5_A5A5_A5A5);

    // asynchronous reset mid-run
    write_reg(8'h00, 32'h1);
    repeat (6) tick();
    check("t7_pre_en", 64'(ising_en), 1);
    #2 axi_rstn = 1'b0;
    #1;
    check("t7_en",   64'(ising_en), 0);
    check("t7_busy", 64'(busy), 0);
    check("t7_flags", {59'd0, ising_clr, snap_valid, done, aborted, 1'b0}, 0);
    check("t7_cnt",  64'(run_cnt), 0);
    check("t7_snap", snap, 0);
    tick();
    axi_rstn = 1'b1;
    tick();
    check("t7_idle", 64'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
